ebus_dev: RTL

- Generic EBUS device-side responder: answers EBOX-initiated CONO/CONI/DATAO/DATAI/PI-serve transfers addressed to its controller select.
- Returns read data through the same XXXdrivingEBUS / XXX_EBUS pair the top-level EBUS mux consumes.
- Buffers DATAO words in a small FIFO toward a local consumer; holds one DATAI word from a local producer.
- Raises a PI request when input data is ready.

---
 rtl/ebus_dev_if.sv | 24 ++
 rtl/ebus_dev.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_dev_if.sv
// EBUS device-side signal bundle: EBOX request lines toward the device and
// the device's acknowledge, read data and PI request back toward the EBOX.
interface ebus_dev_if;
  logic [0:6]  ebusCS;
  logic [0:2]  ebusFunc;
  logic        ebusDemand;
  logic [0:35] EBUS;
  logic        ebusXfer;
  logic        DEVdrivingEBUS;
  logic [0:35] DEV_EBUS;
  logic [1:7]  piReq;

  // EBOX side: issues requests, observes acknowledge and read data
  modport master (
    output ebusCS, ebusFunc, ebusDemand, EBUS,
    input  ebusXfer, DEVdrivingEBUS, DEV_EBUS, piReq
  );

  // Device side: observes requests, returns acknowledge and read data
  modport slave (
    input  ebusCS, ebusFunc, ebusDemand, EBUS,
    output ebusXfer, DEVdrivingEBUS, DEV_EBUS, piReq
  );
endinterface

// File: rtl/ebus_dev.sv
// Generic EBUS device responder. Answers CONO/CONI/DATAO/DATAI/PI-serve
// transfers for its controller select, queues DATAO words toward a local
// consumer, holds one DATAI word from a local producer and raises a PI
// request while input data is ready.
module ebus_dev #(
  parameter logic [0:6]  DEVNUM = 7'd4,
  parameter int          DEPTH  = 4,
  parameter logic [0:17] VECTOR = 18'o000040
) (
  input  logic        clk,
  input  logic        reset,
  ebus_dev_if.slave   bus,
  output logic [0:35] outData,
  output logic        outValid,
  input  logic        outReady,
  input  logic [0:35] inData,
  input  logic        inValid,
  output logic        inReady
);

  // DEPTH is restricted to 2 or 4, so pointers are 1 or 2 bits and wrap naturally
  localparam int              PW        = (DEPTH > 2) ? 2 : 1;
  localparam logic [2:0]      DEPTH_CNT = 3'(DEPTH);
  localparam logic [PW-1:0]   LAST_PTR  = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    STALL = 2'd2,
    IGN   = 2'd3
  } stateType;

  stateType      state, nextState;

  logic [0:35]   fifoMem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [2:0]    count;

  logic [0:35]   holdReg;
  logic          holdFull;
  logic          done;
  logic [0:2]    piLevel;

  logic [0:35]   rdLatch;
  logic          isRead;

  logic          match, fifoFull, doPop, canPush, load, flush;
  logic          doPush, conoHit, dataiHit, capture, captureRead;
  logic [0:35]   captureData, coniWord;
  logic [1:7]    piNext;

  assign match    = bus.ebusDemand && (bus.ebusCS == DEVNUM);
  assign fifoFull = (count == DEPTH_CNT);
  assign outValid = (count != 3'd0);
  assign outData  = fifoMem[rdPtr];
  assign doPop    = outValid && outReady;
  // A pop in the same cycle frees the slot the push needs
  assign canPush  = !fifoFull || doPop;
  assign inReady  = !holdFull;
  assign load     = inValid && !holdFull;
  assign flush    = conoHit && bus.EBUS[31];
  assign coniWord = {27'd0, count, holdFull, fifoFull, done, piLevel};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state decode and the one-shot side-effect strobes of each transfer
  always_comb begin
    nextState   = state;
    doPush      = 1'b0;
    conoHit     = 1'b0;
    dataiHit    = 1'b0;
    capture     = 1'b0;
    captureRead = 1'b0;
    captureData = 36'd0;
    case (state)
      IDLE: begin
        if (match) begin
          case (bus.ebusFunc)
            3'd0: begin
              nextState   = ACK;
              capture     = 1'b1;
              captureRead = 1'b1;
              captureData = coniWord;
            end
            3'd1: begin
              nextState = ACK;
              conoHit   = 1'b1;
              capture   = 1'b1;
            end
            3'd2: begin
              nextState   = ACK;
              dataiHit    = 1'b1;
              capture     = 1'b1;
              captureRead = 1'b1;
              captureData = holdReg;
            end
            3'd3: begin
              if (canPush) begin
                nextState = ACK;
                doPush    = 1'b1;
                capture   = 1'b1;
              end else begin
                nextState = STALL;
              end
            end
            3'd4: begin
              if (bus.piReq != 7'd0) begin
                nextState   = ACK;
                capture     = 1'b1;
                captureRead = 1'b1;
                captureData = {18'd0, VECTOR};
              end else begin
                nextState = IGN;
              end
            end
            default: nextState = IGN;
          endcase
        end else begin
          nextState = IDLE;
        end
      end
      ACK: begin
        if (!bus.ebusDemand) nextState = IDLE;
        else                 nextState = ACK;
      end
      STALL: begin
        if (!bus.ebusDemand) begin
          nextState = IDLE;
        end else if (canPush) begin
          nextState = ACK;
          doPush    = 1'b1;
          capture   = 1'b1;
        end else begin
          nextState = STALL;
        end
      end
      IGN: begin
        if (!bus.ebusDemand) nextState = IDLE;
        else                 nextState = IGN;
      end
      default: nextState = IDLE;
    endcase
  end

  // DATAO FIFO: flush beats push/pop; simultaneous push and pop keep the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fifoMem[i] <= 36'd0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= 3'd0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= 3'd0;
    end else begin
      if (doPush) begin
        fifoMem[wrPtr] <= bus.EBUS;
        wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + PW'(1);
      end
      if (doPop) begin
        rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + PW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // One-hot PI request for the programmed level while DONE is set
  always_comb begin
    piNext = 7'd0;
    if (done && (piLevel != 3'd0)) piNext = 7'b1000000 >> (piLevel - 3'd1);
    else                           piNext = 7'd0;
  end

  // Holding register, DONE and PI level; a producer load wins over a DATAI clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holdReg   <= 36'd0;
      holdFull  <= 1'b0;
      done      <= 1'b0;
      piLevel   <= 3'd0;
      bus.piReq <= 7'd0;
    end else begin
      if (load) holdReg <= inData;
      if (load)                      holdFull <= 1'b1;
      else if (dataiHit && holdFull) holdFull <= 1'b0;
      if (load)                                              done <= 1'b1;
      else if ((dataiHit && holdFull) || (conoHit && bus.EBUS[32])) done <= 1'b0;
      if (conoHit) piLevel <= bus.EBUS[33:35];
      bus.piReq <= piNext;
    end
  end

  // Bus outputs lag entry to ACK by one edge and drop on the edge that sees demand low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdLatch            <= 36'd0;
      isRead             <= 1'b0;
      bus.ebusXfer       <= 1'b0;
      bus.DEVdrivingEBUS <= 1'b0;
      bus.DEV_EBUS       <= 36'd0;
    end else begin
      if (capture) begin
        rdLatch <= captureData;
        isRead  <= captureRead;
      end
      bus.ebusXfer       <= (state == ACK) && bus.ebusDemand;
      bus.DEVdrivingEBUS <= (state == ACK) && bus.ebusDemand && isRead;
      bus.DEV_EBUS       <= ((state == ACK) && bus.ebusDemand && isRead) ? rdLatch : 36'd0;
    end
  end

endmodule
